// File: rtl/pan_pkg.sv
// Shared definitions for the stereo pan mixer: FSM states and pan constants.
package pan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_L,
        ST_MUL_R,
        ST_OUT
    } pan_state_t;

    localparam logic [15:0] PAN_CENTER = 16'h4000;
    localparam logic [15:0] PAN_MAX    = 16'h7FFF;

endpackage

// File: rtl/pan_slew.sv
// Combinational slew limiter: moves the current pan toward the target by at
// most one step. Pan values are 15-bit magnitudes, so no arithmetic overflows.
module pan_slew (
    input  logic [15:0] target,
    input  logic [15:0] current,
    input  logic [15:0] step,
    output logic [15:0] next_pan
);

    logic [15:0] diff;

    // Jump straight to the target when close enough, otherwise take one step toward it
    always_comb begin
        diff     = '0;
        next_pan = current;
        if (target >= current) begin
            diff     = target - current;
            next_pan = (diff <= step) ? target : current + step;
        end else begin
            diff     = current - target;
            next_pan = (diff <= step) ? target : current - step;
        end
    end

endmodule

// File: rtl/stereo_pan_mixer.sv
// Mono-to-stereo panner with a slew-limited pan coefficient and one shared
// multiplier time-sliced between the left and right gains.
module stereo_pan_mixer
    import pan_pkg::*;
#(
    parameter logic [15:0] PAN_STEP = 16'h0040
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        SAMPLE_VALID,
    input  logic [15:0] MONO_IN,
    input  logic [15:0] PAN_IN,
    output logic [15:0] LEFT_OUT,
    output logic [15:0] RIGHT_OUT,
    output logic        OUT_VALID,
    output logic        BUSY,
    output logic        OVERRUN
);

    pan_state_t  state;
    logic [15:0] sample_q;
    logic [15:0] pan_cur;
    logic [15:0] hold_l;
    logic [15:0] pan_target;
    logic [15:0] pan_next;
    logic [15:0] gain;
    logic [32:0] prod;
    logic [15:0] mul_res;
    logic        unused_prod_bits;

    // Negative pan requests saturate to full right before slewing
    assign pan_target = PAN_IN[15] ? PAN_MAX : PAN_IN;

    pan_slew u_slew (
        .target   (pan_target),
        .current  (pan_cur),
        .step     (PAN_STEP),
        .next_pan (pan_next)
    );

    // Single multiplier: left gain during MUL_L, right gain otherwise.
    // Operands are extended to the full 33-bit product width so the modular
    // unsigned product equals the signed sample x non-negative gain product.
    assign gain    = (state == ST_MUL_L) ? (PAN_MAX - pan_cur) : pan_cur;
    assign prod    = {{17{sample_q[15]}}, sample_q} * {17'b0, gain};
    assign mul_res = prod[30:15];
    assign unused_prod_bits = ^{prod[32:31], prod[14:0]};

    assign BUSY = (state != ST_IDLE);

    // Sequencer: accept, multiply left, multiply right, present outputs
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= ST_IDLE;
            sample_q  <= '0;
            pan_cur   <= PAN_CENTER;
            hold_l    <= '0;
            LEFT_OUT  <= '0;
            RIGHT_OUT <= '0;
            OUT_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (SAMPLE_VALID && state != ST_IDLE) begin
                OVERRUN <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (SAMPLE_VALID) begin
                        sample_q <= MONO_IN;
                        pan_cur  <= pan_next;
                        state    <= ST_MUL_L;
                    end
                end
                ST_MUL_L: begin
                    hold_l <= mul_res;
                    state  <= ST_MUL_R;
                end
                ST_MUL_R: begin
                    // Right result goes straight to the output register so
                    // both channels and OUT_VALID are visible during OUT.
                    LEFT_OUT  <= hold_l;
                    RIGHT_OUT <= mul_res;
                    OUT_VALID <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// Self-checking bench for stereo_pan_mixer: directed table, corner-case
// sequences and randomized traffic against an arithmetic reference model.
module tb_stereo_pan_mixer;

    localparam logic [15:0] STEP = 16'h0040;

    logic        clk;
    logic        RESET;
    logic        SAMPLE_VALID;
    logic [15:0] MONO_IN;
    logic [15:0] PAN_IN;
    logic [15:0] LEFT_OUT;
    logic [15:0] RIGHT_OUT;
    logic        OUT_VALID;
    logic        BUSY;
    logic        OVERRUN;

    int n_tests = 0;
    int n_fail  = 0;
    int model_pan = 16384;

    stereo_pan_mixer #(.PAN_STEP(STEP)) dut (
        .CLOCK_50     (clk),
        .RESET        (RESET),
        .SAMPLE_VALID (SAMPLE_VALID),
        .MONO_IN      (MONO_IN),
        .PAN_IN       (PAN_IN),
        .LEFT_OUT     (LEFT_OUT),
        .RIGHT_OUT    (RIGHT_OUT),
        .OUT_VALID    (OUT_VALID),
        .BUSY         (BUSY),
        .OVERRUN      (OVERRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mono;
        logic [15:0] pan;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pan target after clamping, then limited to one step from the current value
    function automatic int ref_slew(input int tgt_raw, input int cur);
        int tgt;
        int d;
        tgt = (tgt_raw >= 32768) ? 32767 : tgt_raw;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d <= int'(STEP)) return tgt;
        return (tgt > cur) ? cur + int'(STEP) : cur - int'(STEP);
    endfunction

    // floor(mono * gain / 32768) as a 16-bit pattern
    function automatic logic [15:0] ref_scale(input logic [15:0] mono, input int gain);
        longint p;
        longint q;
        logic [15:0] s;
        s = mono;
        p = longint'($signed(s)) * longint'(gain);
        q = p / 32768;
        if (p < 0 && q * 32768 != p) q = q - 1;
        return q[15:0];
    endfunction

    task automatic ref_step(input logic [15:0] mono, input logic [15:0] pan,
                            output logic [15:0] el, output logic [15:0] er);
        model_pan = ref_slew(int'(pan), model_pan);
        el = ref_scale(mono, 32767 - model_pan);
        er = ref_scale(mono, model_pan);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        SAMPLE_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RESET = 1'b0;
        model_pan = 16384;
    endtask

    // One strobe; returns outputs and the cycle count to OUT_VALID (0 = timeout)
    task automatic strobe(input logic [15:0] mono, input logic [15:0] pan,
                          output logic [15:0] l, output logic [15:0] r, output int lat);
        @(negedge clk);
        MONO_IN = mono;
        PAN_IN = pan;
        SAMPLE_VALID = 1'b1;
        @(negedge clk);
        SAMPLE_VALID = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (OUT_VALID) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        l = LEFT_OUT;
        r = RIGHT_OUT;
    endtask

    initial begin
        logic [15:0] l, r, el, er;
        int lat;
        int pulses;

        RESET = 1'b1;
        SAMPLE_VALID = 1'b0;
        MONO_IN = '0;
        PAN_IN = '0;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);

        check("reset_left", 32'(LEFT_OUT), 32'h0);
        check("reset_right", 32'(RIGHT_OUT), 32'h0);
        check("reset_valid", 32'(OUT_VALID), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);
        check("reset_overrun", 32'(OVERRUN), 32'h0);

        // Centre-pan table: pan stays at 0x4000 throughout
        vecs[0] = '{mono: 16'h4000, pan: 16'h4000, exp_l: 16'h1FFF, exp_r: 16'h2000};
        vecs[1] = '{mono: 16'h8000, pan: 16'h4000, exp_l: 16'hC001, exp_r: 16'hC000};
        vecs[2] = '{mono: 16'hFFFF, pan: 16'h4000, exp_l: 16'hFFFF, exp_r: 16'hFFFF};
        vecs[3] = '{mono: 16'h0001, pan: 16'h4000, exp_l: 16'h0000, exp_r: 16'h0000};
        vecs[4] = '{mono: 16'h7FFF, pan: 16'h4000, exp_l: 16'h3FFE, exp_r: 16'h3FFF};
        vecs[5] = '{mono: 16'h0000, pan: 16'h4000, exp_l: 16'h0000, exp_r: 16'h0000};

        for (int i = 0; i < 6; i++) begin
            strobe(vecs[i].mono, vecs[i].pan, l, r, lat);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("tbl%0d_left", i), 32'(l), 32'(vecs[i].exp_l));
            check($sformatf("tbl%0d_right", i), 32'(r), 32'(vecs[i].exp_r));
            @(negedge clk);
            check($sformatf("tbl%0d_pulse_width", i), 32'(OUT_VALID), 32'h0);
            check($sformatf("tbl%0d_hold_left", i), 32'(LEFT_OUT), 32'(vecs[i].exp_l));
            check($sformatf("tbl%0d_busy_low", i), 32'(BUSY), 32'h0);
        end

        // Second strobe one cycle after the first is dropped and flagged
        do_reset();
        @(negedge clk);
        MONO_IN = 16'h4000; PAN_IN = 16'h4000; SAMPLE_VALID = 1'b1;
        @(negedge clk);
        MONO_IN = 16'h7FFF; PAN_IN = 16'h7FFF;
        @(negedge clk);
        SAMPLE_VALID = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (OUT_VALID) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("ovr_seen_valid", 32'(lat != 0), 32'h1);
        check("ovr_first_left", 32'(LEFT_OUT), 32'h1FFF);
        check("ovr_first_right", 32'(RIGHT_OUT), 32'h2000);
        check("ovr_flag", 32'(OVERRUN), 32'h1);
        repeat (10) @(negedge clk);
        check("ovr_sticky", 32'(OVERRUN), 32'h1);
        strobe(16'h4000, 16'h4000, l, r, lat);
        check("ovr_next_latency", 32'(lat), 32'd3);
        check("ovr_next_left", 32'(l), 32'h1FFF);
        check("ovr_next_right", 32'(r), 32'h2000);

        // Reset during MUL_R aborts the sample
        @(negedge clk);
        MONO_IN = 16'h1000; PAN_IN = 16'h4000; SAMPLE_VALID = 1'b1;
        @(negedge clk);
        SAMPLE_VALID = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        model_pan = 16384;
        check("abort_left", 32'(LEFT_OUT), 32'h0);
        check("abort_right", 32'(RIGHT_OUT), 32'h0);
        check("abort_valid", 32'(OUT_VALID), 32'h0);
        check("abort_busy", 32'(BUSY), 32'h0);
        check("abort_overrun", 32'(OVERRUN), 32'h0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (OUT_VALID) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'h0);

        // Strobe coincident with reset is ignored
        @(negedge clk);
        RESET = 1'b1; SAMPLE_VALID = 1'b1; MONO_IN = 16'h1234; PAN_IN = 16'h7FFF;
        @(negedge clk);
        RESET = 1'b0; SAMPLE_VALID = 1'b0;
        check("rst_strobe_busy", 32'(BUSY), 32'h0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (OUT_VALID) pulses++;
        end
        check("rst_strobe_no_pulse", 32'(pulses), 32'h0);
        check("rst_strobe_overrun", 32'(OVERRUN), 32'h0);

        // Clamp: 0xFFFF acts as full right; first step lands on 0x4040
        do_reset();
        strobe(16'h4000, 16'hFFFF, l, r, lat);
        ref_step(16'h4000, 16'hFFFF, el, er);
        check("clamp_latency", 32'(lat), 32'd3);
        check("clamp_left", 32'(l), 32'h1FDF);
        check("clamp_right", 32'(r), 32'h2020);
        check("clamp_model_pan", 32'(model_pan), 32'h4040);
        check("clamp_model_right", 32'(r), 32'(er));

        // Full slew to the right edge, then the most negative sample
        do_reset();
        for (int i = 0; i < 256; i++) begin
            strobe(16'h0000, 16'h7FFF, l, r, lat);
            ref_step(16'h0000, 16'h7FFF, el, er);
        end
        check("slew_last_latency", 32'(lat), 32'd3);
        check("slew_model_pan", 32'(model_pan), 32'h7FFF);
        strobe(16'h8000, 16'h7FFF, l, r, lat);
        check("edge_right", 32'(r), 32'h8001);
        check("edge_left", 32'(l), 32'h0000);

        // Randomized traffic at one strobe per four cycles
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [15:0] m;
            logic [15:0] p;
            m = 16'($urandom);
            case ($urandom_range(0, 3))
                0: p = 16'($urandom);
                1: p = 16'($urandom_range(0, 32767));
                2: p = 16'(model_pan + $urandom_range(0, 128) - 64);
                default: p = (i % 2 == 0) ? 16'h0000 : 16'h7FFF;
            endcase
            strobe(m, p, l, r, lat);
            ref_step(m, p, el, er);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("rnd%0d_left", i), 32'(l), 32'(el));
            check($sformatf("rnd%0d_right", i), 32'(r), 32'(er));
        end
        check("rnd_no_overrun", 32'(OVERRUN), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_pan_mixer.md
STEREO_PAN_MIXER -- requirements
Module: stereo_pan_mixer

Interface
REQ-001 Parameter PAN_STEP, default 16'h0040: maximum change of the applied pan per accepted sample, unsigned, 1..16'h7FFF.
REQ-002 CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 SAMPLE_VALID  in  1  one-cycle strobe; MONO_IN and PAN_IN are valid on that cycle.
REQ-005 MONO_IN  in  16  signed two's-complement mono sample.
REQ-006 PAN_IN  in  16  target pan coefficient, 16'h0000 = full left, 16'h4000 = centre, 16'h7FFF = full right.
REQ-007 LEFT_OUT  out  16  signed left-channel sample, registered.
REQ-008 RIGHT_OUT  out  16  signed right-channel sample, registered.
REQ-009 OUT_VALID  out  1  one-cycle pulse when LEFT_OUT/RIGHT_OUT update.
REQ-010 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-011 OVERRUN  out  1  sticky flag: a SAMPLE_VALID arrived while BUSY; cleared only by RESET.

Function
REQ-012 FSM states: IDLE -> MUL_L -> MUL_R -> OUT -> IDLE; one cycle per state except IDLE.
REQ-013 In IDLE, SAMPLE_VALID=1 latches MONO_IN and updates the applied pan, then moves to MUL_L; otherwise stays in IDLE.
REQ-014 SAMPLE_VALID in any non-IDLE state is discarded, sets OVERRUN and does not disturb the operation in flight.
REQ-015 Pan clamp: PAN_IN[15]=1 is treated as 16'h7FFF before slew.
REQ-016 Slew on accept: if |target - pan_cur| <= PAN_STEP then pan_cur = target, else pan_cur moves PAN_STEP toward target; the updated pan_cur is used for that same sample.
REQ-017 Gains: g_R = pan_cur, g_L = 16'h7FFF - pan_cur; both unsigned 15-bit values.
REQ-018 One shared signed multiplier: MONO (16-bit signed) x {1'b0, gain} (17-bit signed) gives a 33-bit product; result = product >>> 15 (floor), low 16 bits taken.
REQ-019 Because gain <= 16'h7FFF, |result| <= |MONO|, so no saturation logic is used; the minimum result is -32767.
REQ-020 MUL_L computes the left result into a holding register; MUL_R computes the right result.
REQ-021 In OUT, LEFT_OUT and RIGHT_OUT load simultaneously and OUT_VALID=1 for exactly that cycle.
REQ-022 Latency: SAMPLE_VALID accepted in cycle N -> OUT_VALID in cycle N+3; maximum throughput is one sample per 4 cycles.
REQ-023 Outputs hold their last values between OUT_VALID pulses.

Reset
REQ-024 RESET forces state IDLE, LEFT_OUT=0, RIGHT_OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0, pan_cur=16'h4000 and clears the sample/holding registers.
REQ-025 RESET mid-operation aborts the sample in flight; no OUT_VALID is produced for it.
REQ-026 SAMPLE_VALID coincident with RESET is ignored.

Structure
REQ-027 Package pan_pkg holds the FSM state enum, PAN_CENTER=16'h4000 and PAN_MAX=16'h7FFF.
REQ-028 Slew limiter is the sub-module pan_slew (inputs: target, current, step; output: next pan), purely combinational, instantiated once.
REQ-029 Exactly one multiplier instance, muxed between g_L and g_R by state.

Verification
REQ-030 After reset, PAN_IN=16'h4000, MONO_IN=16'h4000, strobe once -> OUT_VALID 3 cycles later with RIGHT_OUT=16'h2000 and LEFT_OUT=16'h1FFF.
REQ-031 PAN_IN=16'h7FFF held, 256 strobes of MONO_IN=0 -> pan_cur reaches 16'h7FFF on strobe 256; next strobe with MONO_IN=16'h8000 -> RIGHT_OUT=16'h8001, LEFT_OUT=16'h0000.
REQ-032 PAN_IN=16'hFFFF -> behaves identically to 16'h7FFF (clamp); after the first strobe pan_cur=16'h4040.
REQ-033 Second SAMPLE_VALID 1 cycle after the first -> ignored, OVERRUN=1 and stays 1; the first sample's outputs are unaffected; a strobe after BUSY falls is accepted normally.
REQ-034 RESET asserted in MUL_R -> next cycle all outputs are 0, BUSY=0 and no OUT_VALID pulse follows.
REQ-035 Random MONO_IN/PAN_IN at a 1-in-4-cycle strobe rate vs. a reference model (slew + floor arithmetic) -> bit-exact match and no OVERRUN.
